core_mc: RTL and testbench
==========================

# core_mc

Parametrised multicycle successor to the single-cycle 9-bit core top-level. It fetches, decodes and executes one instruction at a time under an explicit state machine. Instruction and data memories sit outside the block behind request/acknowledge handshakes, so they may have variable latency. It adds a start/done run handshake, a busy flag and a saturating cycle counter. The block sits at the top of the CPU hierarchy, between the testbench or SoC and the two memories.

## Interface
- `DW`, 8: data and register width.
- `RW`, 3: register-pointer width; the block has 2^RW registers.
- `PW`, 8: PC width.
- `CW`, 16: cycle-counter width.
- `START_PC`, 0: PC loaded on each start.
- The instruction width `IW` is derived internally as 3+2*RW (9 at defaults); it is not a parameter.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins a run when the block is not busy.
- `busy`  out  1  high from start acceptance until HALT executes.
- `done`  out  1  high after HALT; held until the next accepted start.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  PW  fetch address (current PC).
- `imem_ack`  in  1  fetch complete; `imem_data` is valid this cycle.
- `imem_data`  in  IW  instruction word.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_addr`  out  DW  data address.
- `dmem_wdata`  out  DW  store data.
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid this cycle for loads.
- `dmem_rdata`  in  DW  load data.
- `cycles`  out  CW  active-cycle count of the current or last run.

## Operation
- Field layout: `op`=inst[IW-1:IW-3], `fa`=inst[2RW-1:RW], `fb`=inst[RW-1:0]. R[x] denotes register x.
- `kADD` 000: R[fa] = R[fa]+R[fb], mod 2^DW.
- `kLSR` 001: R[fa] = R[fa] >> (fb+1), zero fill.
- `kLSL` 010: R[fa] = R[fa] << (fb+1).
- `kLDI` 011: R[1] = zero-extended {fa,fb}.
- `kLDR` 100: R[fa] = mem[R[fb]].
- `kSTR` 101: mem[R[fb]] = R[fa].
- `kBNZ` 110: if R[fa]≠0, PC = PC + sign-extend(R[fb]) mod 2^PW; otherwise PC+1.
- `kHLT` 111: halt; the `fa`/`fb` fields are ignored.
- States: IDLE, FETCH, EXEC, MEM, DONE.
  - IDLE or DONE with `start`=1 → FETCH. PC=`START_PC`, `cycles`=0, `done`=0, `busy`=1.
  - FETCH: `imem_req`=1 and `imem_addr`=PC. On `imem_ack`, latch `imem_data` → EXEC.
  - EXEC, ALU op or BNZ: write the result and update PC → FETCH.
  - EXEC, LDR or STR → MEM.
  - EXEC, HLT → DONE. `busy`=0, `done`=1, PC is not advanced.
  - MEM: `dmem_req`=1, address and data taken from the registers latched in EXEC. On `dmem_ack`, write R[fa] for a load and set PC=PC+1 → FETCH.
- PC+1 wraps modulo 2^PW.
- Registers persist across runs; only reset clears them.
- `start` while busy is ignored.
- `cycles` increments in FETCH, EXEC and MEM and saturates at all-ones.

## Timing
- Reset values:
  - State IDLE.
  - PC=`START_PC`.
  - All registers 0.
  - `busy`, `done`, `imem_req`, `dmem_req`, `dmem_we` all 0.
  - `imem_addr`=`START_PC`.
  - `dmem_addr`, `dmem_wdata` = 0.
  - `cycles`=0.
- Asserting `reset` mid-run aborts immediately. Any outstanding request drops combinationally with the asynchronous reset, and a late ack is ignored.
- Handshake rules:
  - A request stays high, with address and data stable, until the cycle its ack is sampled high.
  - The request deasserts on the next cycle.
  - An ack seen while no request is high is ignored.
- Latency:
  - ALU, LDI and BNZ: 1 + fetch wait + 1 cycles.
  - LDR and STR: add 1 + data wait cycles.
  - With zero-wait memories (ack in the request cycle), ALU instructions take 2 cycles and memory instructions take 3.
- `done` rises the cycle after EXEC of HLT. A `start` in that DONE cycle is accepted.

## Structure
- The `definitions` package holds the opcode constants `kADD`…`kHLT` and the `core_state_t` enum.
- Sub-module `rf_p`: a parametrised register file (DW, RW) with two combinational reads, one synchronous write, and asynchronous clear on reset.
- The ALU and the state machine are inline in `core_mc`.

## Test plan
- Run LDI #5, ADD R1,R1, HLT with zero-wait memories → R1=10, `done` rises 6 cycles after start, `cycles`=6.
- LDI #3 → R1, then STR R1→mem[R1], then LDR R2←mem[R1], with `dmem_ack` delayed 3 cycles each → request held steady 4 cycles, R2=3.
- BNZ countdown loop (R2=3, R3=-1 (0xFF), loop body ADD R2,R3; BNZ R2,R4 with R4 = -2 (0xFE)) → loop runs 3 times, R2=0, final PC=HLT address.
- PW=4, `START_PC`=15, first instruction ADD → second fetch at `imem_addr`=0.
- `start` pulsed while busy, and `reset` asserted while `imem_req` is high → the start is ignored; on reset, all outputs return to reset values the same cycle, and a later ack is ignored.
- Second start after DONE → `done` clears, `cycles` restarts at 0, registers keep their previous values.

Source files
------------

// File: rtl/core_mc_pkg.sv
// Shared opcode constants and controller state type for the multicycle core.
package definitions;

    localparam logic [2:0] kADD = 3'b000;
    localparam logic [2:0] kLSR = 3'b001;
    localparam logic [2:0] kLSL = 3'b010;
    localparam logic [2:0] kLDI = 3'b011;
    localparam logic [2:0] kLDR = 3'b100;
    localparam logic [2:0] kSTR = 3'b101;
    localparam logic [2:0] kBNZ = 3'b110;
    localparam logic [2:0] kHLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_DONE
    } core_state_t;

endpackage

// File: rtl/core_mc_rf_p.sv
// Register file: two combinational read ports, one synchronous write port,
// cleared asynchronously by the active-low reset.
module rf_p #(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    localparam int NR = 1 << RW;

    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];

    // Next register contents: single write port updates one entry.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/core_mc.sv
// Multicycle core: fetch/execute/memory sequencing behind req/ack memories,
// with a start/done run handshake and a saturating active-cycle counter.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_FETCH | imem request held at PC until ack
// ST_EXEC  | decode + ALU/branch writeback, or latch memory operands
// ST_MEM   | dmem request held with latched address/data until ack
// ST_DONE  | HLT executed; done high until the next start
module core_mc
    import definitions::*;
#(
    parameter int DW       = 8,
    parameter int RW       = 3,
    parameter int PW       = 8,
    parameter int CW       = 16,
    parameter int START_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              imem_req,
    output logic [PW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [2*RW+2:0]   imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DW-1:0]     dmem_addr,
    output logic [DW-1:0]     dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DW-1:0]     dmem_rdata,
    output logic [CW-1:0]     cycles
);

    localparam int          IW  = 3 + 2 * RW;
    localparam int          XW  = (PW > DW) ? PW : DW;
    localparam logic [PW-1:0] PC0 = PW'(START_PC);

    core_state_t state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [DW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;
    logic [CW-1:0] cycles_q, cycles_d;

    logic [2:0]    op;
    logic [RW-1:0] fa, fb;
    logic [DW-1:0] ra, rb;
    logic [RW:0]   shamt;
    logic [DW-1:0] alu_res;
    logic [PW-1:0] pc_inc, pc_br;
    logic signed [XW-1:0] br_off;

    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign op     = inst_q[IW-1 -: 3];
    assign fa     = inst_q[2*RW-1 -: RW];
    assign fb     = inst_q[RW-1:0];
    assign shamt  = {1'b0, fb} + (RW+1)'(1);
    assign pc_inc = pc_q + PW'(1);
    // Branch offset is the register value taken as signed, resized to PC width.
    assign br_off = XW'($signed(rb));
    assign pc_br  = pc_q + br_off[PW-1:0];

    rf_p #(
        .DW (DW),
        .RW (RW)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (fa),
        .raddr_b (fb),
        .rdata_a (ra),
        .rdata_b (rb)
    );

    // ALU result for the register-writing opcodes.
    always_comb begin
        alu_res = ra;
        case (op)
            kADD:    alu_res = ra + rb;
            kLSR:    alu_res = ra >> shamt;
            kLSL:    alu_res = ra << shamt;
            kLDI:    alu_res = DW'({fa, fb});
            default: alu_res = ra;
        endcase
    end

    // Next-state, PC, operand latch, writeback and cycle-count logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        cycles_d = cycles_q;
        rf_we    = 1'b0;
        rf_waddr = fa;
        rf_wdata = alu_res;

        if ((state_q inside {ST_FETCH, ST_EXEC, ST_MEM}) && (cycles_q != '1)) begin
            cycles_d = cycles_q + CW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = PC0;
                    cycles_d = '0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op)
                    kADD, kLSR, kLSL: begin
                        rf_we   = 1'b1;
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                    kLDI: begin
                        rf_we    = 1'b1;
                        rf_waddr = RW'(1);
                        pc_d     = pc_inc;
                        state_d  = ST_FETCH;
                    end
                    kBNZ: begin
                        pc_d    = (ra != '0) ? pc_br : pc_inc;
                        state_d = ST_FETCH;
                    end
                    kLDR, kSTR: begin
                        maddr_d  = rb;
                        mwdata_d = ra;
                        state_d  = ST_MEM;
                    end
                    default: begin
                        // HLT: PC stays on the halt instruction.
                        state_d = ST_DONE;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (op == kLDR) begin
                        rf_we    = 1'b1;
                        rf_wdata = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC0;
            inst_q   <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            cycles_q <= cycles_d;
        end
    end

    // Requests decode straight from state so reset drops them immediately.
    assign busy       = state_q inside {ST_FETCH, ST_EXEC, ST_MEM};
    assign done       = (state_q == ST_DONE);
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = (state_q == ST_MEM) && (op == kSTR);
    assign dmem_addr  = maddr_q;
    assign dmem_wdata = mwdata_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: table vectors, directed multi-cycle sequences and random
// straight-line programs checked against an instruction-level model.
module tb_core_mc;
    import definitions::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start;
    logic       busy, done, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic [8:0] imem_data;
    logic [15:0] cycles;

    logic       start2, busy2, done2, imem_req2, imem_ack2, dmem_req2, dmem_we2, dmem_ack2;
    logic [3:0] imem_addr2;
    logic [8:0] imem_data2;
    logic [7:0] dmem_addr2, dmem_wdata2, dmem_rdata2;
    logic [15:0] cycles2;

    core_mc dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .cycles(cycles)
    );

    core_mc #(.PW(4), .START_PC(15)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ack(dmem_ack2), .dmem_rdata(dmem_rdata2), .cycles(cycles2)
    );

    logic [8:0] imem   [256];
    logic [7:0] dmem   [256];
    logic [7:0] m_dmem [256];
    logic [7:0] m_regs [8];

    int n_checks = 0;
    int n_errors = 0;
    int i_wait = 0, d_wait = 0, i_cnt, d_cnt, d_hold, d_unstable = 0;
    int watch_addr = -1, watch_cnt = 0;
    int hold_q[$];
    logic i_force = 1'b0;
    logic [7:0] d_addr0, d_wd0;
    logic d_we0;

    typedef struct {
        logic [8:0] i0;
        logic [8:0] i1;
        int         iw;
        int         dw;
        logic [7:0] exp_r1;
        int         exp_cyc;
    } vec_t;

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
        return {op, a, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Memory responders: ack after a fixed number of wait cycles per request.
    initial begin
        imem_ack = 0; imem_data = '0; dmem_ack = 0; dmem_rdata = '0;
        i_cnt = 0; d_cnt = 0; d_hold = 0;
        forever begin
            @(negedge clk);
            if (imem_req && i_cnt >= i_wait) begin
                imem_ack  = 1'b1;
                imem_data = imem[imem_addr];
                i_cnt     = 0;
                if (int'(imem_addr) == watch_addr) watch_cnt++;
            end else begin
                imem_ack = i_force;
                if (imem_req) i_cnt++; else i_cnt = 0;
            end
            if (dmem_req) begin
                if (d_hold == 0) begin
                    d_addr0 = dmem_addr; d_wd0 = dmem_wdata; d_we0 = dmem_we;
                end else if (dmem_addr !== d_addr0 || dmem_wdata !== d_wd0 || dmem_we !== d_we0) begin
                    d_unstable++;
                end
                d_hold++;
                if (d_cnt >= d_wait) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    dmem_rdata = dmem[dmem_addr];
                    hold_q.push_back(d_hold);
                    d_hold = 0;
                    d_cnt  = 0;
                end else begin
                    dmem_ack = 1'b0;
                    d_cnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                d_cnt    = 0;
                d_hold   = 0;
            end
        end
    end

    // Instruction-level model: executes the program in imem on m_regs/m_dmem.
    task automatic model_run(output int cyc, output int pc_end);
        int pc, steps;
        logic [8:0] ins;
        logic [2:0] op, a, b;
        pc = 0; cyc = 0; steps = 0;
        while (steps < 4000) begin
            ins = imem[pc];
            op = ins[8:6]; a = ins[5:3]; b = ins[2:0];
            cyc += 2 + i_wait;
            steps++;
            if (op == 3'd7) break;
            case (op)
                3'd0: m_regs[a] = m_regs[a] + m_regs[b];
                3'd1: m_regs[a] = m_regs[a] >> (int'(b) + 1);
                3'd2: m_regs[a] = m_regs[a] << (int'(b) + 1);
                3'd3: m_regs[1] = {2'b00, a, b};
                3'd4: begin cyc += 1 + d_wait; m_regs[a] = m_dmem[m_regs[b]]; end
                3'd5: begin cyc += 1 + d_wait; m_dmem[m_regs[b]] = m_regs[a]; end
                default: ;
            endcase
            if (op == 3'd6 && m_regs[a] != 0) pc = (pc + int'($signed(m_regs[b]))) & 255;
            else pc = (pc + 1) & 255;
        end
        if (cyc > 65535) cyc = 65535;
        pc_end = pc;
    endtask

    // Start a run (called at a negedge), wait for done, compare against the model.
    task automatic run_program(input int iw, input int dw, input string tag);
        int n, ecyc, epc, bad;
        i_wait = iw; d_wait = dw;
        m_dmem = dmem;
        model_run(ecyc, epc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, busy, 1);
        check({tag, " done cleared"}, done, 0);
        check({tag, " cycles restart"}, cycles, 0);
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done latency"}, n, ecyc);
        check({tag, " cycles"}, cycles, ecyc);
        check({tag, " halt pc"}, imem_addr, epc);
        check({tag, " busy at end"}, busy, 0);
        for (int r = 0; r < 8; r++)
            check($sformatf("%s R%0d", tag, r), dut.u_rf.regs_q[r], m_regs[r]);
        bad = 0;
        for (int k = 0; k < 256; k++) if (dmem[k] !== m_dmem[k]) bad++;
        check({tag, " dmem diffs"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[6];
        logic [8:0] hlt;
        hlt = enc(kHLT, 3'd0, 3'd0);
        vt[0] = '{enc(kLDI, 3'd0, 3'd5), enc(kADD, 3'd1, 3'd1), 0, 0, 8'd10, 6};
        vt[1] = '{enc(kLDI, 3'd5, 3'd4), enc(kLSR, 3'd1, 3'd1), 0, 0, 8'd11, 6};
        vt[2] = '{enc(kLDI, 3'd7, 3'd7), enc(kLSL, 3'd1, 3'd3), 1, 0, 8'hF0, 9};
        vt[3] = '{enc(kLDI, 3'd5, 3'd0), enc(kADD, 3'd1, 3'd1), 2, 0, 8'd80, 12};
        vt[4] = '{enc(kLDI, 3'd7, 3'd7), enc(kLSR, 3'd1, 3'd7), 0, 1, 8'd0, 6};
        vt[5] = '{enc(kLDI, 3'd4, 3'd1), enc(kLSL, 3'd1, 3'd0), 3, 0, 8'd66, 15};

        for (int k = 0; k < 256; k++) begin imem[k] = hlt; dmem[k] = 8'($urandom); end
        for (int r = 0; r < 8; r++) m_regs[r] = '0;
        start = 0; start2 = 0; imem_ack2 = 0; imem_data2 = '0; dmem_ack2 = 0; dmem_rdata2 = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset imem_req", imem_req, 0);
        check("reset imem_addr", imem_addr, 0);
        check("reset cycles", cycles, 0);
        check("reset dmem_req", dmem_req, 0);
        reset = 1'b1;
        @(negedge clk);

        // PW=4, START_PC=15: PC wraps to 0 after the first instruction.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("pw4 first fetch req", imem_req2, 1);
        check("pw4 first fetch addr", imem_addr2, 15);
        imem_ack2 = 1'b1;
        @(negedge clk);
        imem_ack2 = 1'b0;
        check("pw4 exec no req", imem_req2, 0);
        @(negedge clk);
        check("pw4 second fetch req", imem_req2, 1);
        check("pw4 second fetch addr", imem_addr2, 0);
        imem_data2 = hlt;
        imem_ack2  = 1'b1;
        @(negedge clk);
        imem_ack2 = 1'b0;
        @(negedge clk);
        check("pw4 done", done2, 1);
        check("pw4 cycles", cycles2, 4);

        // Table vectors: LDI, one ALU op on R1, HLT.
        for (int v = 0; v < 6; v++) begin
            imem[0] = vt[v].i0; imem[1] = vt[v].i1; imem[2] = hlt;
            run_program(vt[v].iw, vt[v].dw, $sformatf("vec%0d", v));
            check($sformatf("vec%0d R1 table", v), dut.u_rf.regs_q[1], vt[v].exp_r1);
            check($sformatf("vec%0d cycles table", v), cycles, vt[v].exp_cyc);
        end

        // Store then load with a 3-cycle data wait.
        imem[0] = enc(kLDI, 3'd0, 3'd3);
        imem[1] = enc(kSTR, 3'd1, 3'd1);
        imem[2] = enc(kLDR, 3'd2, 3'd1);
        imem[3] = hlt;
        hold_q.delete();
        d_unstable = 0;
        run_program(0, 3, "mem");
        check("mem access count", hold_q.size(), 2);
        check("mem store hold", hold_q[0], 4);
        check("mem load hold", hold_q[1], 4);
        check("mem req stable", d_unstable, 0);
        check("mem R2", dut.u_rf.regs_q[2], 3);
        check("mem dmem[3]", dmem[3], 3);
        check("mem cycles hand", cycles, 16);

        // Start while busy is ignored; reset mid-fetch aborts; late ack ignored.
        i_wait = 100000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy start cycles", cycles, 4);
        check("busy start req", imem_req, 1);
        @(negedge clk);
        check("busy start ignored", cycles, 5);
        check("busy start pc", imem_addr, 0);
        #2 reset = 1'b0;
        #1;
        check("abort imem_req", imem_req, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort cycles", cycles, 0);
        check("abort imem_addr", imem_addr, 0);
        check("abort dmem_req", dmem_req, 0);
        check("abort dmem_we", dmem_we, 0);
        check("abort dmem_addr", dmem_addr, 0);
        check("abort dmem_wdata", dmem_wdata, 0);
        for (int r = 0; r < 8; r++) begin
            m_regs[r] = '0;
            check($sformatf("abort R%0d", r), dut.u_rf.regs_q[r], 0);
        end
        @(negedge clk);
        reset  = 1'b1;
        i_wait = 0;
        #1;
        imem_data = hlt;
        i_force   = 1'b1;
        repeat (3) @(negedge clk);
        #1 i_force = 1'b0;
        @(negedge clk);
        check("late ack busy", busy, 0);
        check("late ack done", done, 0);
        check("late ack req", imem_req, 0);
        check("late ack cycles", cycles, 0);

        // BNZ countdown loop from a fresh register file.
        dmem[0] = 8'hFF;
        dmem[1] = 8'hFE;
        imem[0] = enc(kLDR, 3'd3, 3'd0);
        imem[1] = enc(kLDI, 3'd0, 3'd1);
        imem[2] = enc(kLDR, 3'd4, 3'd1);
        imem[3] = enc(kLDI, 3'd0, 3'd3);
        imem[4] = enc(kADD, 3'd2, 3'd1);
        imem[5] = enc(kADD, 3'd2, 3'd3);
        imem[6] = enc(kADD, 3'd5, 3'd0);
        imem[7] = enc(kBNZ, 3'd2, 3'd4);
        imem[8] = hlt;
        watch_addr = 5;
        watch_cnt  = 0;
        run_program(1, 1, "bnz");
        watch_addr = -1;
        check("bnz loop count", watch_cnt, 3);
        check("bnz R2", dut.u_rf.regs_q[2], 0);
        check("bnz halt addr", imem_addr, 8);

        // Restart from the first DONE cycle; registers persist.
        imem[0] = enc(kADD, 3'd2, 3'd4);
        imem[1] = hlt;
        run_program(0, 0, "restart");
        check("restart R2", dut.u_rf.regs_q[2], 8'hFE);
        check("restart R3 kept", dut.u_rf.regs_q[3], 8'hFF);
        check("restart cycles hand", cycles, 4);

        // Random straight-line programs.
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(3, 16);
            for (int j = 0; j < n; j++)
                imem[j] = {3'($urandom_range(0, 5)), 6'($urandom)};
            imem[n] = hlt;
            run_program($urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
